// File: rtl/clk_div_meter_pkg.sv
// Shared types and defaults for the clock-ratio meter.
// State encoding plus default counter width and inactivity limit.
package clk_div_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_e;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_TIMEOUT = 1048576;

endpackage

// File: rtl/clk_edge_sync.sv
// Two-flop synchroniser with a history flop; rise pulses for one clk cycle per input rising edge.
// Latency: two clk edges from first sample to rise; no backpressure.
module clk_edge_sync (
  input  logic clk,
  input  logic rstn,
  input  logic clk_in,
  output logic s2,
  output logic rise
);

  logic s1;
  logic s3;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/clk_div_meter.sv
// Measures period and high time of a slow clock-like input in clk cycles, with lock and inactivity detection.
// Results register on the clk edge that consumes the rise; meas_valid is a one-cycle pulse, no backpressure.
module clk_div_meter
  import clk_div_meter_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 0,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             meas_en,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] TO_V   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOL_V  = CNT_W'(TOL);
  localparam logic [MW-1:0]    LOCK_V = MW'(LOCK_CNT);

  logic s2;
  logic rise;

  clk_edge_sync u_sync (
    .clk    (clk),
    .rstn   (rstn),
    .clk_in (clk_in),
    .s2     (s2),
    .rise   (rise)
  );

  state_e           state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [CNT_W-1:0] hcnt_q, hcnt_n;
  logic [MW-1:0]    match_q, match_n;
  logic             prev_vld_q, prev_vld_n;
  logic [CNT_W-1:0] period_n, high_n;
  logic             valid_n, locked_n, timeout_n;

  logic [CNT_W-1:0] diff;
  logic             is_match;
  logic [MW-1:0]    match_inc;

  // cnt_q is the candidate new period; compare it against the last reported one.
  assign diff      = (cnt_q >= period) ? (cnt_q - period) : (period - cnt_q);
  assign is_match  = prev_vld_q && (diff <= TOL_V);
  assign match_inc = (match_q == LOCK_V) ? match_q : match_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      hcnt_q     <= '0;
      match_q    <= '0;
      prev_vld_q <= 1'b0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      hcnt_q     <= hcnt_n;
      match_q    <= match_n;
      prev_vld_q <= prev_vld_n;
      period     <= period_n;
      high_time  <= high_n;
      meas_valid <= valid_n;
      locked     <= locked_n;
      timeout    <= timeout_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    hcnt_n     = hcnt_q;
    match_n    = match_q;
    prev_vld_n = prev_vld_q;
    period_n   = period;
    high_n     = high_time;
    valid_n    = 1'b0;
    locked_n   = locked;
    timeout_n  = timeout;

    if (!meas_en) begin
      state_n    = IDLE;
      cnt_n      = '0;
      hcnt_n     = '0;
      match_n    = '0;
      prev_vld_n = 1'b0;
      locked_n   = 1'b0;
      timeout_n  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_n    = ARM;
          cnt_n      = '0;
          hcnt_n     = '0;
          match_n    = '0;
          prev_vld_n = 1'b0;
          locked_n   = 1'b0;
          timeout_n  = 1'b0;
        end
        ARM: begin
          if (rise) begin
            state_n    = MEASURE;
            cnt_n      = CNT_W'(1);
            hcnt_n     = CNT_W'(1);
            prev_vld_n = 1'b0;
            timeout_n  = 1'b0;
          end else if (cnt_q == TO_V) begin
            cnt_n     = '0;
            match_n   = '0;
            locked_n  = 1'b0;
            timeout_n = 1'b1;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_n   = cnt_q;
            high_n     = hcnt_q;
            valid_n    = 1'b1;
            cnt_n      = CNT_W'(1);
            hcnt_n     = CNT_W'(1);
            prev_vld_n = 1'b1;
            timeout_n  = 1'b0;
            if (is_match) begin
              match_n  = match_inc;
              locked_n = (match_inc == LOCK_V);
            end else begin
              match_n  = '0;
              locked_n = 1'b0;
            end
          end else if (cnt_q == TO_V) begin
            state_n    = ARM;
            cnt_n      = '0;
            hcnt_n     = '0;
            match_n    = '0;
            prev_vld_n = 1'b0;
            locked_n   = 1'b0;
            timeout_n  = 1'b1;
          end else begin
            cnt_n  = cnt_q + 1'b1;
            hcnt_n = hcnt_q + CNT_W'(s2);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
